rsp_buff: RTL and testbench

Response buffer for the controller-to-host path. The controller pushes 32-bit status/result words into an ENT_NUM-deep FIFO. The host drains the FIFO with AXI reads to the response region. It is the read-side counterpart of the command buffer: it sits between the controller's response output and the AXI read-data mux. Reads to an empty FIFO are held for a bounded number of cycles before an error completion is returned.

---
 rtl/rsp_buff.sv | 180 ++++++++++++++++++
 tb/tb_rsp_buff.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsp_buff.sv
// rsp_buff: response buffer between the controller's response output and the
// AXI read-data mux.
//
// The controller pushes RDATA_WIDTH-bit status/result words into an
// ENT_NUM-deep circular FIFO. The host drains it with single-cycle AXI read
// pulses to the response region:
//   offset 0x0 POP: returns the head word. If the FIFO is empty, the read
//                   waits up to TIMEOUT cycles and then completes with err=1.
//   offset 0x4 STATUS: returns the zero-extended occupancy. Nothing is popped.
//   any other offset: completes with err=1 and data=0.
//
// Ports:
//   clk, rst            - clock; synchronous active-high reset
//   ctrl_rsp_buff_vld   - controller push request
//   ctrl_rsp_buff_data  - word to push
//   rsp_buff_ctrl_rdy   - push accepted this cycle (combinational ~full)
//   axi_rd_vld          - AXI read request pulse
//   axi_rd_addr         - read address; only bits [3:0] are decoded
//   axi_rd_region       - region select; matched against AXI_RSP_FIFO_REGION
//   axi_rd_data         - registered read data, valid with axi_rd_done
//   axi_rd_done         - one-cycle completion pulse
//   axi_rd_err          - registered error flag, valid with axi_rd_done
//   rsp_buff_cnt        - registered FIFO occupancy

`ifndef AXI_RSP_FIFO_REGION
`define AXI_RSP_FIFO_REGION 2'b10
`endif

module rsp_buff #(
    parameter int unsigned ENT_NUM      = 4,
    parameter int unsigned RDATA_WIDTH  = 32,
    parameter int unsigned ARADDR_WIDTH = 11,
    parameter int unsigned TIMEOUT      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ctrl_rsp_buff_vld,
    input  logic [RDATA_WIDTH-1:0]     ctrl_rsp_buff_data,
    output logic                       rsp_buff_ctrl_rdy,
    input  logic                       axi_rd_vld,
    input  logic [ARADDR_WIDTH-1:0]    axi_rd_addr,
    input  logic [1:0]                 axi_rd_region,
    output logic [RDATA_WIDTH-1:0]     axi_rd_data,
    output logic                       axi_rd_done,
    output logic                       axi_rd_err,
    output logic [$clog2(ENT_NUM):0]   rsp_buff_cnt
);

    localparam int unsigned PTR_W = $clog2(ENT_NUM);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e                 state_q, state_d;
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic [RDATA_WIDTH-1:0] mem_q [ENT_NUM];

    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [RDATA_WIDTH-1:0] data_q, data_d;

    logic                   full, empty, push, pop, rd_req;
    logic [3:0]             offset;

    // Upper address bits are decoded upstream (region select).
    logic unused_addr_bits;
    assign unused_addr_bits = ^axi_rd_addr[ARADDR_WIDTH-1:4];

    assign full   = (cnt_q == CNT_W'(ENT_NUM));
    assign empty  = (cnt_q == '0);
    assign push   = ctrl_rsp_buff_vld & ~full;
    assign offset = axi_rd_addr[3:0];
    // Reads arriving while a pop is already waiting are ignored.
    assign rd_req = axi_rd_vld & (axi_rd_region == `AXI_RSP_FIFO_REGION) & (state_q == StIdle);

    assign rsp_buff_ctrl_rdy = ~full;
    assign rsp_buff_cnt      = cnt_q;
    assign axi_rd_done       = done_q;
    assign axi_rd_err        = err_q;
    assign axi_rd_data       = data_q;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pop     = 1'b0;
        done_d  = 1'b0;
        err_d   = err_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                if (rd_req) begin
                    case (offset)
                        4'h0: begin
                            if (!empty) begin
                                pop    = 1'b1;
                                done_d = 1'b1;
                                err_d  = 1'b0;
                                data_d = mem_q[rd_ptr_q];
                            end else begin
                                // A push in this same cycle is served from StWait.
                                state_d = StWait;
                                timer_d = '0;
                            end
                        end
                        4'h4: begin
                            done_d = 1'b1;
                            err_d  = 1'b0;
                            data_d = RDATA_WIDTH'(cnt_q);
                        end
                        default: begin
                            done_d = 1'b1;
                            err_d  = 1'b1;
                            data_d = '0;
                        end
                    endcase
                end
            end
            StWait: begin
                if (!empty) begin
                    pop     = 1'b1;
                    done_d  = 1'b1;
                    err_d   = 1'b0;
                    data_d  = mem_q[rd_ptr_q];
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + 1'b1;
                    // Timer reaches TIMEOUT this cycle: error completion next cycle.
                    if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        data_d  = '0;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            timer_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            done_q  <= done_d;
            err_q   <= err_d;
            data_q  <= data_d;
            // ENT_NUM is a power of two, so pointers wrap naturally.
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage is not reset; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= ctrl_rsp_buff_data;
    end

endmodule

// File: tb/tb_rsp_buff.sv
`ifndef AXI_RSP_FIFO_REGION
`define AXI_RSP_FIFO_REGION 2'b10
`endif

module tb_rsp_buff;

    logic        clk = 1'b0;
    logic        rst;
    logic        ctrl_rsp_buff_vld;
    logic [31:0] ctrl_rsp_buff_data;
    logic        rsp_buff_ctrl_rdy;
    logic        axi_rd_vld;
    logic [10:0] axi_rd_addr;
    logic [1:0]  axi_rd_region;
    logic [31:0] axi_rd_data;
    logic        axi_rd_done;
    logic        axi_rd_err;
    logic [2:0]  rsp_buff_cnt;

    int nvec = 0;
    int nerr = 0;

    localparam logic [1:0] REG = `AXI_RSP_FIFO_REGION;

    always #5 clk = ~clk;

    rsp_buff dut (
        .clk                (clk),
        .rst                (rst),
        .ctrl_rsp_buff_vld  (ctrl_rsp_buff_vld),
        .ctrl_rsp_buff_data (ctrl_rsp_buff_data),
        .rsp_buff_ctrl_rdy  (rsp_buff_ctrl_rdy),
        .axi_rd_vld         (axi_rd_vld),
        .axi_rd_addr        (axi_rd_addr),
        .axi_rd_region      (axi_rd_region),
        .axi_rd_data        (axi_rd_data),
        .axi_rd_done        (axi_rd_done),
        .axi_rd_err         (axi_rd_err),
        .rsp_buff_cnt       (rsp_buff_cnt)
    );

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_push(input logic v, input logic [31:0] d);
        ctrl_rsp_buff_vld  = v;
        ctrl_rsp_buff_data = d;
    endtask

    task automatic set_read(input logic v, input logic [1:0] reg_sel, input logic [10:0] addr);
        axi_rd_vld    = v;
        axi_rd_region = reg_sel;
        axi_rd_addr   = addr;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_push(1'b0, 32'h0);
        set_read(1'b0, 2'b00, 11'h0);
        step();
        step();
        rst = 1'b0;
        nvec++;
        if (rsp_buff_cnt !== 3'd0) begin
            nerr++; $display("FAIL reset_cnt: got %0d want 0", rsp_buff_cnt);
        end
        nvec++;
        if (rsp_buff_ctrl_rdy !== 1'b1) begin
            nerr++; $display("FAIL reset_rdy: got %b want 1", rsp_buff_ctrl_rdy);
        end
        nvec++;
        if ({axi_rd_done, axi_rd_err, axi_rd_data} !== 34'h0) begin
            nerr++; $display("FAIL reset_out: done=%b err=%b data=%h want 0/0/0",
                             axi_rd_done, axi_rd_err, axi_rd_data);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            set_push(1'b1, 32'hA0 + i);
            step();
            nvec++;
            if (rsp_buff_cnt !== 3'(i + 1)) begin
                nerr++; $display("FAIL fill_cnt%0d: got %0d want %0d", i, rsp_buff_cnt, i + 1);
            end
        end
        nvec++;
        if (rsp_buff_ctrl_rdy !== 1'b0) begin
            nerr++; $display("FAIL fill_rdy_full: got %b want 0", rsp_buff_ctrl_rdy);
        end
        set_push(1'b1, 32'hA4);
        step();
        set_push(1'b0, 32'h0);
        nvec++;
        if (rsp_buff_cnt !== 3'd4) begin
            nerr++; $display("FAIL fill_drop: cnt got %0d want 4", rsp_buff_cnt);
        end
    endtask

    task automatic test_pop();
        for (int i = 0; i < 4; i++) begin
            set_read(1'b1, REG, 11'h0);
            step();
            set_read(1'b0, REG, 11'h0);
            nvec++;
            if (axi_rd_done !== 1'b1 || axi_rd_err !== 1'b0 || axi_rd_data !== 32'hA0 + i) begin
                nerr++; $display("FAIL pop%0d: done=%b err=%b data=%h want 1/0/%h",
                                 i, axi_rd_done, axi_rd_err, axi_rd_data, 32'hA0 + i);
            end
            nvec++;
            if (rsp_buff_cnt !== 3'(3 - i)) begin
                nerr++; $display("FAIL pop_cnt%0d: got %0d want %0d", i, rsp_buff_cnt, 3 - i);
            end
        end
        step();
        nvec++;
        if (axi_rd_done !== 1'b0) begin
            nerr++; $display("FAIL pop_done_single: got %b want 0", axi_rd_done);
        end
    endtask

    task automatic test_empty_wait();
        set_read(1'b1, REG, 11'h0);
        step();                         // N+1
        set_read(1'b0, REG, 11'h0);
        nvec++;
        if (axi_rd_done !== 1'b0) begin
            nerr++; $display("FAIL wait_early1: done got %b want 0", axi_rd_done);
        end
        step();                         // N+2
        step();                         // N+3
        set_push(1'b1, 32'h55);
        step();                         // N+4
        set_push(1'b0, 32'h0);
        nvec++;
        if (axi_rd_done !== 1'b0) begin
            nerr++; $display("FAIL wait_early4: done got %b want 0", axi_rd_done);
        end
        step();                         // N+5
        nvec++;
        if (axi_rd_done !== 1'b1 || axi_rd_err !== 1'b0 || axi_rd_data !== 32'h55) begin
            nerr++; $display("FAIL wait_done: done=%b err=%b data=%h want 1/0/00000055",
                             axi_rd_done, axi_rd_err, axi_rd_data);
        end
        nvec++;
        if (rsp_buff_cnt !== 3'd0) begin
            nerr++; $display("FAIL wait_cnt: got %0d want 0", rsp_buff_cnt);
        end
    endtask

    task automatic test_timeout();
        int n;
        n = 0;
        set_read(1'b1, REG, 11'h0);
        step();
        n = 1;
        set_read(1'b0, REG, 11'h0);
        while (axi_rd_done !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        nvec++;
        if (n !== 17) begin
            nerr++; $display("FAIL timeout_latency: got %0d cycles want 17", n);
        end
        nvec++;
        if (axi_rd_done !== 1'b1 || axi_rd_err !== 1'b1 || axi_rd_data !== 32'h0) begin
            nerr++; $display("FAIL timeout_resp: done=%b err=%b data=%h want 1/1/0",
                             axi_rd_done, axi_rd_err, axi_rd_data);
        end
        // Back in idle: normal push then pop.
        set_push(1'b1, 32'h77);
        step();
        set_push(1'b0, 32'h0);
        set_read(1'b1, REG, 11'h0);
        step();
        set_read(1'b0, REG, 11'h0);
        nvec++;
        if (axi_rd_done !== 1'b1 || axi_rd_err !== 1'b0 || axi_rd_data !== 32'h77) begin
            nerr++; $display("FAIL timeout_recover: done=%b err=%b data=%h want 1/0/00000077",
                             axi_rd_done, axi_rd_err, axi_rd_data);
        end
    endtask

    task automatic test_status();
        set_push(1'b1, 32'h11);
        step();
        set_push(1'b1, 32'h22);
        step();
        // STATUS with same-cycle push.
        set_push(1'b1, 32'h33);
        set_read(1'b1, REG, 11'h4);
        step();
        set_push(1'b0, 32'h0);
        set_read(1'b0, REG, 11'h0);
        nvec++;
        if (axi_rd_done !== 1'b1 || axi_rd_err !== 1'b0 || axi_rd_data !== 32'd2) begin
            nerr++; $display("FAIL status: done=%b err=%b data=%h want 1/0/2",
                             axi_rd_done, axi_rd_err, axi_rd_data);
        end
        nvec++;
        if (rsp_buff_cnt !== 3'd3) begin
            nerr++; $display("FAIL status_cnt: got %0d want 3", rsp_buff_cnt);
        end
        set_read(1'b1, REG, 11'h8);
        step();
        set_read(1'b0, REG, 11'h0);
        nvec++;
        if (axi_rd_done !== 1'b1 || axi_rd_err !== 1'b1 || axi_rd_data !== 32'h0
            || rsp_buff_cnt !== 3'd3) begin
            nerr++; $display("FAIL bad_offset: done=%b err=%b data=%h cnt=%0d want 1/1/0/3",
                             axi_rd_done, axi_rd_err, axi_rd_data, rsp_buff_cnt);
        end
        // Other region: ignored.
        set_read(1'b1, 2'b01, 11'h0);
        step();
        set_read(1'b0, REG, 11'h0);
        nvec++;
        if (axi_rd_done !== 1'b0 || rsp_buff_cnt !== 3'd3) begin
            nerr++; $display("FAIL other_region: done=%b cnt=%0d want 0/3",
                             axi_rd_done, rsp_buff_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            set_read(1'b1, REG, 11'h0);
            step();
            set_read(1'b0, REG, 11'h0);
            nvec++;
            if (axi_rd_done !== 1'b1 || axi_rd_data !== 32'h11 * (i + 1)) begin
                nerr++; $display("FAIL status_drain%0d: done=%b data=%h want 1/%h",
                                 i, axi_rd_done, axi_rd_data, 32'h11 * (i + 1));
            end
        end
    endtask

    task automatic test_back_to_back();
        set_push(1'b1, 32'hB0);
        step();
        for (int i = 0; i < 10; i++) begin
            set_push(1'b1, 32'hB1 + i);
            set_read(1'b1, REG, 11'h0);
            step();
            nvec++;
            if (axi_rd_done !== 1'b1 || axi_rd_data !== 32'hB0 + i || rsp_buff_cnt !== 3'd1) begin
                nerr++; $display("FAIL wrap%0d: done=%b data=%h cnt=%0d want 1/%h/1",
                                 i, axi_rd_done, axi_rd_data, rsp_buff_cnt, 32'hB0 + i);
            end
        end
        set_push(1'b0, 32'h0);
        step();
        set_read(1'b0, REG, 11'h0);
        nvec++;
        if (axi_rd_data !== 32'hBA || rsp_buff_cnt !== 3'd0) begin
            nerr++; $display("FAIL wrap_last: data=%h cnt=%0d want 000000ba/0",
                             axi_rd_data, rsp_buff_cnt);
        end
    endtask

    task automatic test_reset_in_wait();
        int seen;
        seen = 0;
        set_read(1'b1, REG, 11'h0);
        step();
        set_read(1'b0, REG, 11'h0);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (axi_rd_done === 1'b1) seen++;
            step();
        end
        nvec++;
        if (seen !== 0) begin
            nerr++; $display("FAIL reset_wait_done: got %0d completions want 0", seen);
        end
        nvec++;
        if (rsp_buff_cnt !== 3'd0 || rsp_buff_ctrl_rdy !== 1'b1) begin
            nerr++; $display("FAIL reset_wait_cnt: cnt=%0d rdy=%b want 0/1",
                             rsp_buff_cnt, rsp_buff_ctrl_rdy);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_pop();
        test_empty_wait();
        test_timeout();
        test_status();
        test_back_to_back();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
